cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//   Run/halt/single-step controller for the single-cycle RV32I core. Gates architectural
//   commit (PC update, regfile/dmem writes) via one enable and halts on EBREAK, illegal
//   opcode, host command, step-count exhaustion or watchdog. Owns cycle/retired counters
//   and reports halt cause and halt PC to the testbench / debug host.
// PARAMETERS
//   CNT_W      32       width of cycle_count / retired_count
//   STEP_W     8        width of step-count argument
//   WDOG_LIMIT 100000   max RUN cycles before forced halt; 0 disables watchdog
//   AUTO_RUN   1        1: leave reset into RUN; 0: leave reset into IDLE
// PORTS
//   clk            in   1       core clock
//   reset          in   1       synchronous, active-high
//   cmd_valid      in   1       host command valid
//   cmd_ready      out  1       command accepted when valid&ready
//   cmd_op         in   2       0 RUN, 1 HALT, 2 STEP, 3 CLEAR
//   cmd_arg        in   STEP_W  step count for STEP (0 treated as 1)
//   ebreak_i       in   1       decoder: current instruction is EBREAK
//   illegal_i      in   1       decoder: current instruction is illegal
//   pc_i           in   32      current PC from fetch
//   cpu_en_o       out  1       commit enable for PC/regfile/dmem (combinational)
//   halted_o       out  1       state == HALTED
//   state_o        out  2       0 IDLE, 1 RUN, 2 STEP, 3 HALTED
//   halt_cause_o   out  3       0 NONE,1 EBREAK,2 ILLEGAL,3 HOST,4 STEP,5 WDOG
//   halt_pc_o      out  32      PC of first un-executed instruction after halt
//   cycle_count    out  CNT_W   cycles spent in RUN or STEP
//   retired_count  out  CNT_W   cycles with cpu_en_o = 1
// BEHAVIOUR
//   Reset: state = AUTO_RUN ? RUN : IDLE; all counters, halt_cause_o, halt_pc_o = 0.
//   cpu_en_o = (RUN|STEP) & ~ebreak_i & ~illegal_i & ~(accepted HALT this cycle);
//     EBREAK/illegal never commit, PC holds at the faulting instruction.
//   cmd_ready = 1 in IDLE, RUN, HALTED; 0 in STEP (step bursts are atomic).
//   IDLE/HALTED: RUN -> RUN (watchdog cleared); STEP n -> STEP with remain = max(n,1);
//     HALT ignored; CLEAR zeros counters, cause := NONE, HALTED -> IDLE.
//   RUN: ebreak_i -> HALTED/EBREAK; illegal_i -> HALTED/ILLEGAL; HALT cmd -> HALTED/HOST;
//     wdog reaching WDOG_LIMIT (when !=0) -> HALTED/WDOG; RUN/STEP cmds accepted, no effect;
//     CLEAR zeros counters, stays RUN.
//   STEP: remain decrements per committed cycle; commit with remain==1 -> HALTED/STEP;
//     ebreak/illegal abort burst with their own cause.
//   Simultaneous halt sources, priority: ILLEGAL > EBREAK > HOST > WDOG > STEP.
//   halt_pc_o <= pc_i on the first HALTED cycle (1-cycle latency); PC is frozen there.
//   cycle_count +1 per RUN/STEP cycle incl. the halting cycle; retired_count +1 when
//     cpu_en_o; both wrap modulo 2^CNT_W. Watchdog counts RUN cycles only, cleared on RUN
//     entry; inactive in STEP.
//   Reset mid-run/mid-step: immediate return to reset state, burst abandoned.
// STRUCTURE
//   Header cpu_ctrl_defs.vh: state, cmd_op and halt_cause localparam encodings, shared
//     with decoder and testbenches.
//   Sub-module run_counter (width param, clear, enable, terminal-match flag), instanced
//     for watchdog and step-remaining; cycle/retired counters inline.
// TESTING
//   AUTO_RUN=1, 6 ALU ops + EBREAK at 0x18 -> retired 6, cycle 7, cause 1, halt_pc 0x18.
//   AUTO_RUN=0, STEP cmd_arg=3 -> exactly 3 cpu_en_o pulses, cause 4, halt_pc 0x0C,
//     cmd_ready low for the 3 cycles.
//   STEP cmd_arg=0 -> one commit, cause 4; then RUN resumes from halt_pc.
//   WDOG_LIMIT=10, `j .` loop -> halt after 10 RUN cycles, cause 5, retired 10.
//   HALT cmd same cycle as ebreak_i -> cause 1 (priority), no commit that cycle;
//     illegal word 0x00000000 at 0x8 -> cause 2, halt_pc 0x8.
//   reset asserted mid-run at cycle 4 -> next cycle counters 0, state RUN, PC restarts;
//     CLEAR in HALTED -> counters 0, cause 0, state IDLE.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the run/halt/step controller: FSM states, host command
// opcodes and halt causes, plus a width helper for limit-sized counters.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_HALT  = 2'd1,
    OP_STEP  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_EBREAK  = 3'd1,
    CAUSE_ILLEGAL = 3'd2,
    CAUSE_HOST    = 3'd3,
    CAUSE_STEP    = 3'd4,
    CAUSE_WDOG    = 3'd5
  } halt_cause_e;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host command channel of the run controller.
// A command transfers on a cycle where cmd_valid and cmd_ready are both high;
// the host holds cmd_op/cmd_arg stable while cmd_valid is high and not yet accepted.
interface cpu_run_ctrl_if #(
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl_run_counter.sv
// Clearable up-counter with a terminal-match flag; used for the watchdog and
// for counting commits inside a step burst.
module cpu_run_ctrl_run_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term_i,
  output logic         term_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == term_i);
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller: gates architectural commit through cpu_en_o,
// records why and where the core stopped, and keeps cycle/retired counters.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int STEP_W     = 8,
  parameter int WDOG_LIMIT = 100000,
  parameter bit AUTO_RUN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  cpu_run_ctrl_if.slave     cmd,
  input  logic              ebreak_i,
  input  logic              illegal_i,
  input  logic [31:0]       pc_i,
  output logic              cpu_en_o,
  output logic              halted_o,
  output logic [1:0]        state_o,
  output logic [2:0]        halt_cause_o,
  output logic [31:0]       halt_pc_o,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired_count
);
  localparam int WDOG_W = cnt_width(WDOG_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_TERM = (WDOG_LIMIT == 0) ? '0 : WDOG_W'(WDOG_LIMIT - 1);
  localparam state_e RESET_STATE = AUTO_RUN ? ST_RUN : ST_IDLE;

  state_e             state_q, state_d;
  halt_cause_e        cause_q, cause_d;
  logic [31:0]        halt_pc_q, halt_pc_d;
  logic               halt_arm_q, halt_arm_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, ret_q, ret_d;
  logic [STEP_W-1:0]  step_tgt_q, step_tgt_d;

  cmd_op_e            op;
  logic [STEP_W-1:0]  arg;
  logic               ready, cmd_fire, idle_like, active, host_halt, cpu_en, clear_cnt;
  logic               wdog_clr, wdog_term, wdog_hit, step_clr, step_en, step_term, step_done;

  assign op        = cmd_op_e'(cmd.cmd_op);
  assign arg       = cmd.cmd_arg;
  assign ready     = (state_q != ST_STEP);
  assign cmd_fire  = cmd.cmd_valid & ready;
  assign idle_like = (state_q == ST_IDLE) | (state_q == ST_HALTED);
  assign active    = (state_q == ST_RUN) | (state_q == ST_STEP);
  assign host_halt = (state_q == ST_RUN) & cmd_fire & (op == OP_HALT);
  // Faulting instructions and the HALT cycle never commit, so PC stays on them.
  assign cpu_en    = active & ~ebreak_i & ~illegal_i & ~host_halt;

  assign wdog_clr  = idle_like & cmd_fire & (op == OP_RUN);
  assign wdog_hit  = (WDOG_LIMIT != 0) & (state_q == ST_RUN) & wdog_term;
  assign step_clr  = idle_like & cmd_fire & (op == OP_STEP);
  assign step_en   = (state_q == ST_STEP) & cpu_en;
  assign step_done = step_en & step_term;

  cpu_run_ctrl_run_counter #(.W(WDOG_W)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdog_clr),
    .en     (state_q == ST_RUN),
    .term_i (WDOG_TERM),
    .term_o (wdog_term)
  );

  // Counts commits already made in the burst; the last one matches target-1.
  cpu_run_ctrl_run_counter #(.W(STEP_W)) u_step (
    .clk    (clk),
    .reset  (reset),
    .clear  (step_clr),
    .en     (step_en),
    .term_i (step_tgt_q - STEP_W'(1)),
    .term_o (step_term)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    step_tgt_d = step_tgt_q;
    clear_cnt  = 1'b0;
    cyc_d      = cyc_q + CNT_W'(active);
    ret_d      = ret_q + CNT_W'(cpu_en);

    if (idle_like && cmd_fire) begin
      case (op)
        OP_RUN:   state_d = ST_RUN;
        OP_STEP: begin
          state_d    = ST_STEP;
          step_tgt_d = (arg == '0) ? STEP_W'(1) : arg;
        end
        OP_CLEAR: begin
          clear_cnt = 1'b1;
          cause_d   = CAUSE_NONE;
          state_d   = ST_IDLE;
        end
        default: ;
      endcase
    end

    if (state_q == ST_RUN && cmd_fire && op == OP_CLEAR) clear_cnt = 1'b1;

    // Halt sources in priority order; HOST/WDOG only fire in RUN, STEP only in STEP.
    if (active) begin
      if (illegal_i) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_ILLEGAL;
      end else if (ebreak_i) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_EBREAK;
      end else if (host_halt) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_HOST;
      end else if (wdog_hit) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_WDOG;
      end else if (step_done) begin
        state_d = ST_HALTED;
        cause_d = CAUSE_STEP;
      end
    end

    if (clear_cnt) begin
      cyc_d = '0;
      ret_d = '0;
    end

    halt_arm_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
    halt_pc_d  = halt_arm_q ? pc_i : halt_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      cause_q    <= CAUSE_NONE;
      halt_pc_q  <= '0;
      halt_arm_q <= 1'b0;
      cyc_q      <= '0;
      ret_q      <= '0;
      step_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      halt_pc_q  <= halt_pc_d;
      halt_arm_q <= halt_arm_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
      step_tgt_q <= step_tgt_d;
    end
  end

  assign cmd.cmd_ready  = ready;
  assign cpu_en_o       = cpu_en;
  assign halted_o       = (state_q == ST_HALTED);
  assign state_o        = state_q;
  assign halt_cause_o   = cause_q;
  assign halt_pc_o      = halt_pc_q;
  assign cycle_count    = cyc_q;
  assign retired_count  = ret_q;
endmodule
